// File: rtl/matrix_stream_loader_pkg.sv
// Shared sizing helpers for the matrix stream loader/unloader family.
//   port2d_width : packed width of an H x W matrix of bitlength-bit elements
//   elem_offset  : bit offset of element (i,j) in a row-major packed matrix
//   idx_width    : width of an index counting 0..n-1, never narrower than 1 bit
package matrix_stream_loader_pkg;

    localparam int unsigned DefBitlength = 8;
    localparam int unsigned DefH         = 3;
    localparam int unsigned DefW         = 4;

    function automatic int unsigned port2d_width(input int unsigned h, input int unsigned w,
                                                 input int unsigned bl);
        return h * w * bl;
    endfunction

    function automatic int unsigned elem_offset(input int unsigned i, input int unsigned j,
                                                input int unsigned w, input int unsigned bl);
        return (i * w + j) * bl;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Handshake bundle of the matrix stream loader.
//   clr                  : synchronous clear from the controller
//   in_valid/in_ready    : element-serial input stream, in_data row-major
//   mat_valid/mat_ready  : packed matrix output, mat_out element (i,j) at elem_offset(i,j)
//   busy                 : loader holds a partially filled matrix
// master = stream producer and matrix consumer; slave = the loader.
interface matrix_stream_loader_if
    import matrix_stream_loader_pkg::*;
#(
    parameter int unsigned bitlength = DefBitlength,
    parameter int unsigned H         = DefH,
    parameter int unsigned W         = DefW
) ();

    logic                                   clr;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [bitlength-1:0]                   in_data;
    logic                                   mat_valid;
    logic                                   mat_ready;
    logic [port2d_width(H, W, bitlength)-1:0] mat_out;
    logic                                   busy;

    modport master (
        output clr, in_valid, in_data, mat_ready,
        input  in_ready, mat_valid, mat_out, busy
    );

    modport slave (
        input  clr, in_valid, in_data, mat_ready,
        output in_ready, mat_valid, mat_out, busy
    );

endinterface

// File: rtl/matrix_stream_loader_rowcol_counter.sv
// Row-major index counter over an H x W matrix.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : synchronous clear of both indices (wins over inc_i)
//   inc_i       : advance one element; col wraps at W-1 and carries into row
//   row_idx_o   : current row, col_idx_o : current column
//   last_o      : current position is element (H-1, W-1)
module matrix_stream_loader_rowcol_counter
    import matrix_stream_loader_pkg::*;
#(
    parameter int unsigned H    = DefH,
    parameter int unsigned W    = DefW,
    parameter int unsigned RowW = idx_width(H),
    parameter int unsigned ColW = idx_width(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [RowW-1:0] row_idx_o,
    output logic [ColW-1:0] col_idx_o,
    output logic            last_o
);

    localparam logic [RowW-1:0] RowLast = RowW'(H - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(W - 1);

    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic            row_wrap, col_wrap;

    assign row_wrap = (row_q == RowLast);
    assign col_wrap = (col_q == ColLast);

    // With H==1 or W==1 the matching index is always at its last value and stays 0.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_idx_o = row_q;
    assign col_idx_o = col_q;
    assign last_o    = row_wrap && col_wrap;

endmodule

// File: rtl/matrix_stream_loader.sv
// Deserialises a row-major element stream into a packed H x W matrix.
// A fill buffer collects elements while a separate output register holds the
// previous matrix for the consumer, so loading overlaps with the output wait.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of matrix_stream_loader_if (clr, input stream,
//           matrix output, busy)
module matrix_stream_loader
    import matrix_stream_loader_pkg::*;
#(
    parameter int unsigned bitlength = DefBitlength,
    parameter int unsigned H         = DefH,
    parameter int unsigned W         = DefW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_stream_loader_if.slave bus
);

    localparam int unsigned MatWidth = port2d_width(H, W, bitlength);
    localparam int unsigned RowW     = idx_width(H);
    localparam int unsigned ColW     = idx_width(W);
    localparam int unsigned OffW     = idx_width(MatWidth);

    logic [RowW-1:0]     row_idx;
    logic [ColW-1:0]     col_idx;
    logic                last_elem;
    logic [OffW-1:0]     wr_offset;

    logic [MatWidth-1:0] fill_q, fill_d;
    logic [MatWidth-1:0] mat_out_q, mat_out_d;
    logic                fill_full_q, fill_full_d;
    logic                mat_valid_q, mat_valid_d;
    logic                accept, transfer;

    // clr blocks both the input handshake and the buffer-to-output move.
    assign transfer     = fill_full_q && (!mat_valid_q || bus.mat_ready) && !bus.clr;
    assign bus.in_ready = !bus.clr && (!fill_full_q || transfer);
    assign accept       = bus.in_valid && bus.in_ready;

    matrix_stream_loader_rowcol_counter #(
        .H    (H),
        .W    (W),
        .RowW (RowW),
        .ColW (ColW)
    ) u_rowcol_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (bus.clr),
        .inc_i     (accept),
        .row_idx_o (row_idx),
        .col_idx_o (col_idx),
        .last_o    (last_elem)
    );

    assign wr_offset = OffW'(elem_offset(32'(row_idx), 32'(col_idx), W, bitlength));

    always_comb begin
        fill_d = fill_q;
        if (accept) begin
            fill_d[wr_offset +: bitlength] = bus.in_data;
        end
    end

    // Transfer reads fill_q, so a first element of the next matrix written in
    // the same cycle never reaches the output register.
    assign mat_out_d = transfer ? fill_q : mat_out_q;

    always_comb begin
        fill_full_d = fill_full_q;
        mat_valid_d = mat_valid_q;
        if (bus.clr) begin
            fill_full_d = 1'b0;
            mat_valid_d = 1'b0;
        end else begin
            if (transfer) begin
                fill_full_d = 1'b0;
            end
            // Completing a matrix wins over the transfer clear (only possible for 1x1).
            if (accept && last_elem) begin
                fill_full_d = 1'b1;
            end
            if (transfer) begin
                mat_valid_d = 1'b1;
            end else if (mat_valid_q && bus.mat_ready) begin
                mat_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q      <= '0;
            mat_out_q   <= '0;
            fill_full_q <= 1'b0;
            mat_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            mat_out_q   <= mat_out_d;
            fill_full_q <= fill_full_d;
            mat_valid_q <= mat_valid_d;
        end
    end

    assign bus.mat_out   = mat_out_q;
    assign bus.mat_valid = mat_valid_q;
    assign bus.busy      = (row_idx != '0) || (col_idx != '0);

endmodule

// File: tb/tb_matrix_stream_loader.sv
module tb_matrix_stream_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_stream_loader_if #(.bitlength(8), .H(2), .W(2)) ia ();
    matrix_stream_loader_if #(.bitlength(8), .H(1), .W(3)) ib ();

    matrix_stream_loader #(.bitlength(8), .H(2), .W(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    matrix_stream_loader #(.bitlength(8), .H(1), .W(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the 2x2 loader: accepted elements gather in row-major
    // order; every fourth one closes a matrix whose element k sits at byte k.
    logic [7:0]  elem_q[$];
    logic [31:0] exp_q[$];
    int          pop_cyc[$];
    logic [31:0] pop_val[$];
    logic        prev_hold = 1'b0;
    logic        prev_clr  = 1'b0;
    logic [31:0] prev_out  = '0;
    logic [31:0] m;
    logic [31:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            elem_q.delete();
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && !prev_clr) begin
                check("hold_valid", 64'(ia.mat_valid), 64'(1));
                check("hold_data", 64'(ia.mat_out), 64'(prev_out));
            end
            if (ia.mat_valid && ia.mat_ready && !ia.clr) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_matrix: got=%0h expected=none (cycle %0d)",
                             ia.mat_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard", 64'(ia.mat_out), 64'(e));
                    pop_cyc.push_back(cyc);
                    pop_val.push_back(ia.mat_out);
                end
            end
            if (ia.clr) begin
                elem_q.delete();
                exp_q.delete();
            end else if (ia.in_valid && ia.in_ready) begin
                elem_q.push_back(ia.in_data);
                if (elem_q.size() == 4) begin
                    m = '0;
                    for (int k = 0; k < 4; k++) m = m | (32'(elem_q[k]) << (8 * k));
                    exp_q.push_back(m);
                    elem_q.delete();
                end
            end
            prev_hold = ia.mat_valid && !ia.mat_ready;
            prev_out  = ia.mat_out;
            prev_clr  = ia.clr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic        seen;
    logic [23:0] got_b;

    initial begin
        ia.clr = 0; ia.in_valid = 0; ia.in_data = 0; ia.mat_ready = 0;
        ib.clr = 0; ib.in_valid = 0; ib.in_data = 0; ib.mat_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mat_valid", 64'(ia.mat_valid), 64'(0));
        check("rst_busy", 64'(ia.busy), 64'(0));
        check("rst_in_ready", 64'(ia.in_ready), 64'(1));
        check("rst_mat_out", 64'(ia.mat_out), 64'(0));
        check("rst_b_in_ready", 64'(ib.in_ready), 64'(1));

        // Basic load and latency
        for (int k = 0; k < 4; k++) begin
            tick();
            ia.mat_ready = 1; ia.in_valid = 1; ia.in_data = 8'(k + 1);
            @(negedge clk);
            check("basic_in_ready", 64'(ia.in_ready), 64'(1));
        end
        tick();
        ia.in_valid = 0;
        @(negedge clk);
        check("basic_not_early", 64'(ia.mat_valid), 64'(0));
        check("basic_busy_wrapped", 64'(ia.busy), 64'(0));
        tick();
        @(negedge clk);
        check("basic_valid", 64'(ia.mat_valid), 64'(1));
        check("basic_mat_out", 64'(ia.mat_out), 64'(32'h04030201));

        // Back-to-back matrices
        tick();
        pop_cyc.delete(); pop_val.delete();
        ia.mat_ready = 1;
        for (int k = 0; k < 8; k++) begin
            ia.in_valid = 1; ia.in_data = 8'(k + 1);
            @(negedge clk);
            check("b2b_in_ready", 64'(ia.in_ready), 64'(1));
            tick();
        end
        ia.in_valid = 0;
        repeat (4) tick();
        @(negedge clk);
        check("b2b_count", 64'(pop_cyc.size()), 64'(2));
        if (pop_cyc.size() == 2) begin
            check("b2b_spacing", 64'(pop_cyc[1] - pop_cyc[0]), 64'(4));
            check("b2b_second", 64'(pop_val[1]), 64'(32'h08070605));
        end

        // Backpressure
        tick();
        ia.mat_ready = 0;
        for (int k = 0; k < 9; k++) begin
            ia.in_valid = 1; ia.in_data = 8'(16 + k);
            @(negedge clk);
            check("bp_in_ready", 64'(ia.in_ready), 64'(k < 8));
            if (k < 8) tick();
        end
        check("bp_held_valid", 64'(ia.mat_valid), 64'(1));
        check("bp_held_data", 64'(ia.mat_out), 64'(32'h13121110));
        tick();
        @(negedge clk);
        check("bp_still_blocked", 64'(ia.in_ready), 64'(0));
        tick();
        ia.mat_ready = 1;
        @(negedge clk);
        check("bp_release_ready", 64'(ia.in_ready), 64'(1));
        tick();
        ia.in_valid = 0;
        @(negedge clk);
        check("bp_second_valid", 64'(ia.mat_valid), 64'(1));
        check("bp_second_data", 64'(ia.mat_out), 64'(32'h17161514));
        check("bp_ninth_busy", 64'(ia.busy), 64'(1));

        // Clear, then a mid-fill clear
        tick();
        ia.clr = 1; ia.in_valid = 1; ia.in_data = 8'hCC;
        @(negedge clk);
        check("clr_in_ready", 64'(ia.in_ready), 64'(0));
        tick();
        ia.clr = 0; ia.in_valid = 0;
        @(negedge clk);
        check("clr_leftover_busy", 64'(ia.busy), 64'(0));
        tick();
        ia.in_valid = 1; ia.in_data = 8'hAA;
        tick();
        ia.in_data = 8'hBB;
        tick();
        ia.in_valid = 0;
        @(negedge clk);
        check("clr_partial_busy", 64'(ia.busy), 64'(1));
        tick();
        ia.clr = 1;
        tick();
        ia.clr = 0;
        @(negedge clk);
        check("clr_busy", 64'(ia.busy), 64'(0));
        check("clr_mat_valid", 64'(ia.mat_valid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            ia.in_valid = 1; ia.in_data = 8'(8'h11 + k);
            tick();
        end
        ia.in_valid = 0;
        tick();
        @(negedge clk);
        check("clr_refill_valid", 64'(ia.mat_valid), 64'(1));
        check("clr_refill_data", 64'(ia.mat_out), 64'(32'h14131211));

        // Asynchronous reset mid-hold
        tick();
        ia.mat_ready = 0;
        for (int k = 0; k < 5; k++) begin
            ia.in_valid = 1; ia.in_data = 8'(8'h21 + k);
            tick();
        end
        ia.in_valid = 0;
        @(negedge clk);
        check("arst_pre_valid", 64'(ia.mat_valid), 64'(1));
        check("arst_pre_busy", 64'(ia.busy), 64'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_mat_valid", 64'(ia.mat_valid), 64'(0));
        check("arst_busy", 64'(ia.busy), 64'(0));
        check("arst_mat_out", 64'(ia.mat_out), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", 64'(ia.in_ready), 64'(1));
        check("arst_valid_after", 64'(ia.mat_valid), 64'(0));

        // Degenerate 1x3 shape
        ib.mat_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            ib.in_valid = 1; ib.in_data = 8'(5 + k);
            @(negedge clk);
            if (k == 1) check("deg_busy", 64'(ib.busy), 64'(1));
        end
        tick();
        ib.in_valid = 0;
        seen = 0; got_b = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ib.mat_valid) begin
                seen  = 1;
                got_b = ib.mat_out;
                break;
            end
        end
        check("deg_seen", 64'(seen), 64'(1));
        check("deg_mat_out", 64'(got_b), 64'(24'h070605));
        check("deg_busy_after", 64'(ib.busy), 64'(0));

        // Randomised traffic against the scoreboard
        for (int n = 0; n < 3000; n++) begin
            tick();
            ia.in_valid  = ($urandom_range(0, 9) < 7);
            ia.in_data   = 8'($urandom);
            ia.mat_ready = ($urandom_range(0, 9) < 6);
            ia.clr       = ($urandom_range(0, 99) < 2);
        end
        tick();
        ia.clr = 0; ia.in_valid = 0; ia.mat_ready = 1;
        repeat (10) tick();
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
